// File: rtl/xor_range_reg.sv
// DEPTH x WIDTH xor register file with point updates and a sequentially scanned range-xor query.
// Define XOR_RANGE_SWAP_EN to swap reversed bounds instead of reporting out_err.
module xor_range_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    idx_lo,
  input  logic [AW-1:0]    idx_hi,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [1:0] OpXor   = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpRange = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d, hi_q, hi_d;
  logic [WIDTH-1:0] acc_q, acc_d, data_q, data_d;
  logic             err_q, err_d;

  logic             accept;
  logic             bad_range;
  logic             range_err;
  logic [AW-1:0]    lo_eff, hi_eff;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign accept    = in_valid & in_ready;
  assign bad_range = (idx_lo > idx_hi);

`ifdef XOR_RANGE_SWAP_EN
  assign lo_eff    = bad_range ? idx_hi : idx_lo;
  assign hi_eff    = bad_range ? idx_lo : idx_hi;
  assign range_err = 1'b0;
`else
  assign lo_eff    = idx_lo;
  assign hi_eff    = idx_hi;
  assign range_err = bad_range;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept && op == OpRange) begin
          ptr_d   = lo_eff;
          hi_d    = hi_eff;
          acc_d   = '0;
          err_d   = range_err;
          state_d = StScan;
        end
      end
      StScan: begin
        // A bad range spends its single cycle here without reading memory.
        if (err_q) begin
          data_d  = '0;
          state_d = StResp;
        end else begin
          acc_d = acc_q ^ mem_q[ptr_q];
          if (ptr_q == hi_q) begin
            data_d  = acc_q ^ mem_q[hi_q];
            state_d = StResp;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Writes happen only on accept, so memory is frozen during SCAN and RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      unique case (op)
        OpXor:   mem_q[idx_lo] <= mem_q[idx_lo] ^ din;
        OpSet:   mem_q[idx_lo] <= din;
        OpClear: begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
          end
        end
        OpRange: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_range_reg.sv
// Scoreboard bench for xor_range_reg: stimulus pushes expected responses, a monitor pops and checks.
module tb_xor_range_reg;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]    op;
  logic [AW-1:0] idx_lo, idx_hi;
  logic [W-1:0]  din, out_data;

  xor_range_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .idx_lo(idx_lo), .idx_hi(idx_hi), .din(din), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  exp_t         sb[$];
  logic [W-1:0] model [D];
  bit           hold = 1'b0;
  bit           bp_en = 1'b0;
  bit           in_resp = 1'b0;
  logic [W-1:0] held_d;
  logic         held_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 out_ready = hold ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: xor over the inclusive index range of the model array.
  function automatic exp_t model_range(input int lo, input int hi);
    exp_t e;
    int   a = lo;
    int   b = hi;
    e.data = '0;
    e.err  = 1'b0;
    e.acc  = 0;
    if (a > b) begin
`ifdef XOR_RANGE_SWAP_EN
      a = hi;
      b = lo;
`else
      e.err = 1'b1;
      e.lat = 1;
      return e;
`endif
    end
    for (int i = a; i <= b; i++) e.data ^= model[i];
    e.lat = b - a + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      in_resp = 1'b0;
    end else if (out_valid) begin
      if (!in_resp) begin
        chk("resp_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_data", 32'(out_data), 32'(e.data));
          chk("resp_err", 32'(out_err), 32'(e.err));
          chk("resp_latency", cyc - e.acc, e.lat);
        end
        in_resp = 1'b1;
        held_d  = out_data;
        held_e  = out_err;
      end else begin
        chk("hold_data", 32'(out_data), 32'(held_d));
        chk("hold_err", 32'(out_err), 32'(held_e));
      end
      if (out_ready) in_resp = 1'b0;
    end
  end

  // Called and returns at a falling edge; the command is accepted on the next rising edge.
  task automatic send(input logic [1:0] o, input int lo, input int hi, input logic [W-1:0] d,
                      input bit track);
    int   n = 0;
    exp_t e;
    op       = o;
    idx_lo   = AW'(lo);
    idx_hi   = AW'(hi);
    din      = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    case (o)
      2'b00: model[lo] ^= d;
      2'b01: model[lo] = d;
      2'b11: for (int i = 0; i < D; i++) model[i] = '0;
      default: begin
        if (track) begin
          e     = model_range(lo, hi);
          e.acc = cyc + 1;
          sb.push_back(e);
        end
      end
    endcase
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    idx_lo    = '0;
    idx_hi    = '0;
    din       = '0;
    for (int i = 0; i < D; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    reset = 1'b1;
    @(negedge clk);

    send(2'b10, 0, 7, 8'h00, 1'b1);
    send(2'b00, 3, 0, 8'h5A, 1'b0);
    send(2'b00, 3, 0, 8'h0F, 1'b0);
    send(2'b10, 3, 3, 8'h00, 1'b1);
    send(2'b01, 0, 0, 8'hFF, 1'b0);
    send(2'b01, 7, 0, 8'h01, 1'b0);
    send(2'b10, 0, 7, 8'h00, 1'b1);
    send(2'b10, 1, 2, 8'h00, 1'b1);
    send(2'b10, 5, 2, 8'h00, 1'b1);
    drain();

    // Backpressure: a held response blocks commands and the blocked XOR must not land.
    hold = 1'b1;
    @(negedge clk);
    send(2'b10, 0, 7, 8'h00, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("resp_timeout", 32'(out_valid), 1);
    op       = 2'b00;
    idx_lo   = 3'd3;
    din      = 8'hFF;
    in_valid = 1'b1;
    repeat (3) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    n = 0;
    while (out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    send(2'b10, 3, 3, 8'h00, 1'b1);

    send(2'b11, 0, 0, 8'h00, 1'b0);
    send(2'b10, 0, 7, 8'h00, 1'b1);
    send(2'b01, 2, 0, 8'h3C, 1'b0);
    send(2'b01, 6, 0, 8'hC3, 1'b0);
    drain();

    // Reset mid-scan drops the query and wipes memory.
    send(2'b10, 0, 7, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_data", 32'(out_data), 0);
    for (int i = 0; i < D; i++) model[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < D; i++) send(2'b10, i, i, 8'h00, 1'b1);
    drain();

    bp_en = 1'b1;
    for (int k = 0; k < 80; k++) begin
      logic [1:0] o;
      o = 2'($urandom_range(0, 3));
      if (o == 2'b11 && $urandom_range(0, 3) != 0) o = 2'b00;
      send(o, $urandom_range(0, D - 1), $urandom_range(0, D - 1), 8'($urandom), 1'b1);
    end
    drain();
    bp_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_range_reg.md
Name: xor_range_reg

Overview:
- Parametrised successor to the 1-bit, 8-entry xor register.
- Holds DEPTH words of WIDTH bits each.
- Supports point xor, point set and clear-all updates, plus an inclusive range-xor query over [idx_lo, idx_hi].
- Queries are serviced by a sequential scan FSM with valid/ready handshakes on both the command and response sides. It sits as a storage/compute leaf under the bitxor datapath controller.

Parameters:
- WIDTH, 8: bits per entry (>=1).
- DEPTH, 8: number of entries. Power of two, >=2.
- AW, $clog2(DEPTH): index width. Derived localparam, not overridable.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command ready.
- op  in  2  operation code:
  - 00 = XOR: mem[idx_lo] ^= din
  - 01 = SET: mem[idx_lo] = din
  - 10 = RANGE query
  - 11 = CLEAR: all entries = 0
- idx_lo  in  AW  point index / range low bound.
- idx_hi  in  AW  range high bound (RANGE only).
- din  in  WIDTH  update operand.
- out_valid  out  1  query result valid.
- out_ready  in  1  result consumed.
- out_data  out  WIDTH  xor of mem[idx_lo..idx_hi].
- out_err  out  1  bad range (idx_lo > idx_hi), valid with out_valid.

Behaviour:

Reset (reset=0, async):
- All mem entries = 0; state = IDLE.
- in_ready = 1, out_valid = 0, out_data = 0, out_err = 0.
- Takes effect immediately, including mid-scan or mid-response. The pending query is dropped.

Accept:
- A command is accepted on a rising edge with in_valid & in_ready.
- in_ready = 1 only in IDLE.

XOR / SET / CLEAR:
- Memory is written at the accept edge.
- The FSM stays in IDLE and in_ready stays 1, so back-to-back updates are allowed every cycle.
- No response is produced.

RANGE:
- At the accept edge: latch lo/hi; ptr = lo; acc = 0; go to SCAN.

FSM states: IDLE, SCAN, RESP.
- SCAN: each edge, acc ^= mem[ptr].
  - If ptr == hi: out_data = acc ^ mem[hi], out_err = 0, go to RESP.
  - Otherwise ptr++.
- RESP: out_valid = 1.
  - out_data and out_err are held stable until an out_ready edge.
  - On that edge: out_valid = 0, go to IDLE.
  - in_ready = 1 from the following cycle.

Latency:
- out_valid rises (hi - lo + 1) cycles after the accept edge.
- Range lo=0, hi=DEPTH-1 takes DEPTH cycles.

Bad range (lo > hi, macro absent):
- Skip SCAN. Go directly to RESP with out_err = 1, out_data = 0.
- Latency is 1 cycle.

Arithmetic and memory:
- Pure bitwise xor; no carries.
- ptr is AW bits and never wraps, because ptr <= hi <= DEPTH-1.
- Memory is not writable while in SCAN or RESP, so the scan sees a consistent snapshot.

Simultaneous events:
- in_valid while not IDLE: ignored; the command must be held by the source.
- out_ready while not in RESP: ignored.

Optional Feature:

Macro: XOR_RANGE_SWAP_EN
- Defined: when idx_lo > idx_hi, the bounds are swapped at accept.
  - The query returns xor of mem[idx_hi..idx_lo].
  - out_err is tied to 0.
  - Latency is (lo - hi + 1) cycles.
- Undefined: the bad-range error path above applies.

Test Plan (WIDTH=8, DEPTH=8):
1. Reset pulse, then RANGE 0..7 -> in_ready=1 after reset; out_valid after 8 cycles with out_data=0x00, out_err=0.
2. XOR idx3 0x5A, then XOR idx3 0x0F, issued back-to-back; then RANGE 3..3 -> out_data=0x55 exactly 1 cycle after accept.
3. Continuing from 2: SET idx0 0xFF, SET idx7 0x01, then RANGE 0..7 -> out_data=0xAB, latency 8 cycles. Then RANGE 1..2 -> 0x00.
4. Hold out_ready=0 for 3 cycles in RESP while driving in_valid with an XOR -> out_valid/out_data held, in_ready=0, XOR not applied. Release out_ready -> in_ready=1 next cycle.
5. RANGE lo=5, hi=2 with idx3=0x55:
   - Macro absent -> out_err=1, out_data=0x00, latency 1.
   - XOR_RANGE_SWAP_EN defined -> out_data=0x55, out_err=0, latency 4.
6. Two cases:
   - CLEAR then RANGE 0..7 -> 0x00.
   - Start RANGE 0..7 and assert reset on scan cycle 4 -> out_valid=0 and in_ready=1 immediately, all entries read back 0x00.
